// File: rtl/sll_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sll_iter                                                         |
// | Brief   : Iterative logical left shifter, one bit per clock, with a         |
// |           sticky flag for any bit shifted out of the MSB.                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sll_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [15:0] shift,
    input  logic [15:0] alu_in_1,
    output logic [15:0] alu_out,
    output logic        busy,
    output logic        done,
    output logic        lost
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] data_q,  data_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        lost_q,  lost_d;
    logic        w_big_shift;

    assign w_big_shift = |shift[15:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_st_idle;
            data_q  <= 16'h0000;
            cnt_q   <= 4'd0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        lost_d  = lost_q;
        // Flush wins over everything and leaves the datapath untouched.
        if (flush) begin
            state_d = c_st_idle;
        end else begin
            case (state_q)
                c_st_shift: begin
                    lost_d = lost_q | data_q[15];
                    data_d = {data_q[14:0], 1'b0};
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = c_st_done;
                    end
                end
                default: begin
                    if (start) begin
                        lost_d = 1'b0;
                        if (w_big_shift) begin
                            data_d  = 16'h0000;
                            lost_d  = |alu_in_1;
                            state_d = c_st_done;
                        end else if (shift[3:0] == 4'd0) begin
                            data_d  = alu_in_1;
                            state_d = c_st_done;
                        end else begin
                            data_d  = alu_in_1;
                            cnt_d   = shift[3:0];
                            state_d = c_st_shift;
                        end
                    end else begin
                        state_d = c_st_idle;
                    end
                end
            endcase
        end
    end

    always_comb begin
        busy    = (state_q == c_st_shift);
        done    = (state_q == c_st_done);
        alu_out = data_q;
        lost    = lost_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sll_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sll_iter                                                      |
// | Brief   : Directed and randomized checks of sll_iter using a result queue. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sll_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] shift = 16'h0;
    logic [15:0] alu_in_1 = 16'h0;
    logic [15:0] alu_out;
    logic        busy, done, lost;

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] sb_q[$];

    sll_iter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .shift    (shift),
        .alu_in_1 (alu_in_1),
        .alu_out  (alu_out),
        .busy     (busy),
        .done     (done),
        .lost     (lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {lost, result} of a 16-bit logical left shift.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] sh);
        logic [31:0] full;
        if (sh >= 16'd16) return {(a != 16'h0), 16'h0000};
        full = {16'h0000, a} << sh[3:0];
        return {|full[31:16], full[15:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = sb_q.pop_front();
                chk("sb_alu_out", {16'h0, alu_out}, {16'h0, e[15:0]});
                chk("sb_lost", {31'h0, lost}, {31'h0, e[16]});
            end
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] sh,
                         input logic [15:0] exp_out, input logic exp_lost, input string tag);
        int t;
        int busy_n;
        int exp_lat;
        bit got;
        exp_lat = (sh >= 16'd1 && sh <= 16'd15) ? int'(sh) : 0;
        sb_q.push_back({exp_lost, exp_out});
        @(negedge clk);
        start = 1'b1; alu_in_1 = a; shift = sh;
        @(negedge clk);
        start = 1'b0;
        t = 0; busy_n = 0; got = 1'b0;
        while (t < 40) begin
            if (done) begin got = 1'b1; break; end
            if (busy) busy_n++;
            @(negedge clk);
            t++;
        end
        if (!got) t = -1;
        chk({tag, "_latency"}, t, exp_lat);
        chk({tag, "_busy_cycles"}, busy_n, exp_lat);
        @(negedge clk);
        chk({tag, "_done_width"}, {31'h0, done}, 32'd0);
        chk({tag, "_hold_out"}, {16'h0, alu_out}, {16'h0, exp_out});
    endtask

    initial begin
        logic [16:0] r;
        int t, first, second;
        logic [15:0] shs [6];
        shs = '{16'd1, 16'd15, 16'd16, 16'hFFFF, 16'd8, 16'd4};

        #1;
        chk("rst_alu_out", {16'h0, alu_out}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_lost", {31'h0, lost}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        do_op(16'h3ABD, 16'd3,  16'hD5E8, 1'b1, "sh3");
        do_op(16'h3ABD, 16'd7,  16'h5E80, 1'b1, "sh7");
        do_op(16'h3ABD, 16'd2,  16'hEAF4, 1'b0, "sh2");
        do_op(16'h3ABD, 16'd0,  16'h3ABD, 1'b0, "sh0");
        do_op(16'h3ABD, 16'd20, 16'h0000, 1'b1, "sh20");
        do_op(16'h0000, 16'd20, 16'h0000, 1'b0, "sh20_zero");

        // start held high through busy (ignored) and into DONE (accepted).
        r = model(16'h1234, 16'd5); sb_q.push_back(r);
        r = model(16'hC0F1, 16'd5); sb_q.push_back(r);
        @(negedge clk);
        start = 1'b1; alu_in_1 = 16'h1234; shift = 16'd5;
        @(negedge clk);
        alu_in_1 = 16'hC0F1;
        t = 0; first = -1; second = -1;
        while (t < 40) begin
            if (done) begin
                if (first < 0) first = t;
                else begin second = t; start = 1'b0; break; end
            end
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        chk("b2b_first_done", first, 32'd5);
        chk("b2b_second_done", second, 32'd11);
        repeat (3) @(negedge clk);

        // Flush at the second edge after acceptance.
        @(negedge clk);
        start = 1'b1; alu_in_1 = 16'h3ABD; shift = 16'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'h0, busy}, 32'h0);
        chk("flush_done", {31'h0, done}, 32'h0);
        chk("flush_alu_out", {16'h0, alu_out}, 32'h757A);
        chk("flush_lost", {31'h0, lost}, 32'h0);
        // Flush blocks a simultaneous start.
        start = 1'b1; flush = 1'b1; shift = 16'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'h0, busy}, 32'h0);
        chk("flush_start_done", {31'h0, done}, 32'h0);
        repeat (8) @(negedge clk);

        // Asynchronous reset between edges mid-shift.
        start = 1'b1; alu_in_1 = 16'h3ABD; shift = 16'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", {31'h0, busy}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_alu_out", {16'h0, alu_out}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_done", {31'h0, done}, 32'h0);
        chk("arst_lost", {31'h0, lost}, 32'h0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        do_op(16'h8001, 16'd1, 16'h0002, 1'b1, "post_rst");

        for (int i = 0; i < 6; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            r = model(a, shs[i]);
            do_op(a, shs[i], r[15:0], r[16], "rand");
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sll_iter.md
SLL_ITER -- requirements
Module: sll_iter

Interface
REQ-001 The block SHALL have a single clock, and its reset SHALL be asynchronous and active-high.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request a shift; sampled only when busy==0.
REQ-005 Port flush, input, 1 bit: synchronous abort of the operation in progress.
REQ-006 Port shift, input, 16 bits: unsigned left-shift amount, sampled with start.
REQ-007 Port alu_in_1, input, 16 bits: operand, sampled with start.
REQ-008 Port alu_out, output, 16 bits: shifted result; zero-fill from the LSB.
REQ-009 Port busy, output, 1 bit: high while in state SHIFT.
REQ-010 Port done, output, 1 bit: one-cycle pulse marking a valid alu_out.
REQ-011 Port lost, output, 1 bit: OR of every bit shifted out of bit 15; valid with done.

Function
REQ-012 States SHALL be IDLE, SHIFT and DONE, with a 16-bit data register driving alu_out and a 4-bit down-counter cnt.
REQ-013 busy SHALL equal (state==SHIFT), and done SHALL equal (state==DONE), both as registered outputs.
REQ-014 start SHALL be accepted at a rising edge when state is IDLE or DONE, with flush low.
REQ-015 On acceptance with 1<=shift<=15: data<=alu_in_1, cnt<=shift[3:0], lost<=0, state->SHIFT.
REQ-016 On acceptance with shift==0: data<=alu_in_1, lost<=0, state->DONE.
REQ-017 On acceptance with shift>=16: data<=0, lost<=(alu_in_1!=0), state->DONE.
REQ-018 Each SHIFT edge SHALL do lost<=lost|data[15], data<={data[14:0],1'b0}, cnt<=cnt-1; when cnt==1 at that edge, state->DONE.
REQ-019 If start is accepted at edge k with amount N (1..15), done SHALL be high in the cycle following edge k+N.
REQ-020 For N==0 or N>=16, done SHALL be high in the cycle following edge k.
REQ-021 From DONE with no start, state SHALL go to IDLE, so done is exactly one cycle wide.
REQ-022 start in DONE SHALL be accepted (back-to-back), giving a done gap of at least one cycle for N>=1.
REQ-023 start while busy SHALL be ignored and not queued; the running operation SHALL be unaffected.
REQ-024 alu_out and lost SHALL hold their last value in IDLE until the next accepted start.
REQ-025 flush high at an edge SHALL force state->IDLE from any state, suppress done, leave data/lost unchanged, and block a simultaneous start.
REQ-026 The arithmetic SHALL be logical: the result equals (alu_in_1 << N) truncated to 16 bits, with no sign handling.

Reset
REQ-027 rst high SHALL immediately force state=IDLE, alu_out=16'h0000, cnt=0, busy=0, done=0 and lost=0, regardless of clk.
REQ-028 Reset asserted mid-SHIFT SHALL abandon the operation with no done pulse, and the first start after release SHALL behave as from IDLE.

Verification
REQ-029 Shift by 3: alu_in_1=16'h3ABD, shift=3, start for one cycle -> busy high 3 cycles, done after edge k+3, alu_out=16'hD5E8, lost=1.
REQ-030 Shift by 7 and by 2: alu_in_1=16'h3ABD, shift=7 -> alu_out=16'h5E80, lost=1; shift=2 -> alu_out=16'hEAF4, lost=0.
REQ-031 Shift by 0 and by 20: shift=0 -> done after edge k, busy never high, alu_out=16'h3ABD, lost=0; shift=20 -> done after edge k, alu_out=0, lost=1.
REQ-032 Busy and back-to-back start: start with shift=5 raised again while busy -> ignored, single done; start held high during DONE -> second operation accepted, done again 5 edges later.
REQ-033 flush mid-SHIFT: flush at edge k+2 of a shift=7 operation -> state IDLE, no done, busy low the next cycle.
REQ-034 Async reset mid-SHIFT: rst pulsed between edges mid-shift -> all outputs zero before the next edge, no done; a following shift=1 of 16'h8001 gives alu_out=16'h0002, lost=1.
